// File: rtl/fifo_tx_serializer.sv
// Pops words from a synchronous FIFO and sends each one as a start/LSB-first/stop
// serial frame, with every bit held for CLKS_PER_BIT clocks.
module fifo_tx_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             empty_i,
    output logic             rd_en_o,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [CW-1:0]    clk_cnt, clk_cnt_n;
    logic             bit_end;
    logic             tx_n, rd_en_n, busy_n, done_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            clk_cnt <= '0;
            tx_o    <= 1'b1;
            rd_en_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            clk_cnt <= clk_cnt_n;
            tx_o    <= tx_n;
            rd_en_o <= rd_en_n;
            busy_o  <= busy_n;
            done_o  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        clk_cnt_n = clk_cnt;
        bit_end   = (clk_cnt == CLK_LAST);

        case (state)
            IDLE: begin
                if (enable_i && !empty_i) state_n = REQ;
            end
            REQ: begin
                state_n = LOAD;
            end
            LOAD: begin
                // FIFO read data became valid on the edge that saw the read strobe
                shift_n   = rdata_i;
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                state_n   = START;
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    shift_n   = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state register
        tx_n    = (state_n == START) ? 1'b0 :
                  (state_n == DATA)  ? shift_n[0] : 1'b1;
        rd_en_n = (state_n == REQ);
        busy_n  = (state_n != IDLE);
        done_n  = (state == STOP) && (state_n == IDLE);
    end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer: a FIFO model feeds one instance at 4 clocks/bit
// and a scoreboard of expected line bits; a second instance covers 1 clock/bit.
module tb_fifo_tx_serializer;

    localparam int CA = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic       en_a = 1'b0;
    logic       empty_a = 1'b1;
    logic [7:0] rdata_a = 8'h00;
    logic       rd_en_a, tx_a, busy_a, done_a;

    logic       en_b = 1'b0;
    logic       empty_b = 1'b1;
    logic [7:0] rdata_b = 8'h3C;
    logic       rd_en_b, tx_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int rd_err = 0;

    logic [7:0] fifo_q[$];
    logic       exp_q[$];

    fifo_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(CA)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en_a), .empty_i(empty_a),
        .rd_en_o(rd_en_a), .rdata_i(rdata_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
    );

    fifo_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en_b), .empty_i(empty_b),
        .rd_en_o(rd_en_b), .rdata_i(rdata_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
    );

    // Synchronous FIFO read side: data and empty flag update on the edge that samples rd_en
    always @(posedge clk) begin
        if (rd_en_a === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_q.size() == 0) rd_err <= rd_err + 1;
            else rdata_a <= fifo_q.pop_front();
        end
        empty_a <= (fifo_q.size() == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
        exp_q.push_back(1'b1);
    endtask

    // Waits for the start bit, checks every line cycle against the scoreboard, then done_o.
    task automatic recv_frame(input int exp_gap, input int drop_at, input int abort_at);
        int   cnt;
        int   idx;
        bit   aborted;
        logic eb;
        cnt = 0;
        while (tx_a !== 1'b0 && cnt < 200) begin
            cnt++;
            tick();
        end
        chk("start_gap", cnt, exp_gap);
        idx = 0;
        aborted = 0;
        for (int b = 0; b < 10; b++) begin
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            for (int c = 0; c < CA; c++) begin
                if (idx == drop_at) en_a = 1'b0;
                if (idx == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_tx", tx_a, 1'b1);
                    chk("rst_busy", busy_a, 1'b0);
                    chk("rst_rd_en", rd_en_a, 1'b0);
                    aborted = 1;
                end
                if (!aborted) chk("tx_bit", tx_a, eb);
                tick();
                idx++;
            end
        end
        if (aborted) begin
            rst = 1'b0;
        end else begin
            chk("done_pulse", done_a, 1'b1);
            chk("done_busy", busy_a, 1'b0);
        end
    endtask

    initial begin
        int         rd0;
        logic       viol;
        logic [9:0] fb;

        // Reset state
        tick();
        chk("reset_tx", tx_a, 1'b1);
        chk("reset_rd_en", rd_en_a, 1'b0);
        chk("reset_busy", busy_a, 1'b0);
        chk("reset_done", done_a, 1'b0);
        rst = 1'b0;
        tick();

        // Enabled but FIFO empty
        en_a = 1'b1;
        viol = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rd_en_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) viol = 1'b1;
        end
        chk("idle_empty", viol, 1'b0);

        // FIFO holds a word but enable is low
        en_a = 1'b0;
        push_word(8'hA5);
        viol = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rd_en_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) viol = 1'b1;
        end
        chk("idle_disabled", viol, 1'b0);

        // Raising enable starts a frame on the next cycle: 0xA5
        rd0 = rd_cnt;
        en_a = 1'b1;
        tick();
        chk("start_rd_en", rd_en_a, 1'b1);
        chk("start_busy", busy_a, 1'b1);
        recv_frame(2, -1, -1);
        chk("single_reads", rd_cnt - rd0, 1);
        en_a = 1'b0;
        tick();
        chk("done_one_cycle", done_a, 1'b0);

        // Back-to-back 0x00 then 0xFF
        rd0 = rd_cnt;
        push_word(8'h00);
        push_word(8'hFF);
        tick();
        tick();
        en_a = 1'b1;
        recv_frame(3, -1, -1);
        recv_frame(3, -1, -1);
        chk("b2b_reads", rd_cnt - rd0, 2);
        chk("b2b_fifo_empty", fifo_q.size(), 0);
        chk("b2b_rd_err", rd_err, 0);

        // Enable dropped in data bit 3: frame completes, no further read
        rd0 = rd_cnt;
        push_word(8'h5A);
        push_word(8'h33);
        recv_frame(4, 4 * CA, -1);
        viol = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_en_a !== 1'b0 || busy_a !== 1'b0) viol = 1'b1;
        end
        chk("drop_no_req", viol, 1'b0);
        chk("drop_reads", rd_cnt - rd0, 1);
        chk("drop_fifo_left", fifo_q.size(), 1);

        // Reset during data bit 5 of 0x33, then 0xC7 goes out intact
        rd0 = rd_cnt;
        push_word(8'hC7);
        en_a = 1'b1;
        recv_frame(3, -1, 6 * CA);
        recv_frame(3, -1, -1);
        chk("rst_reads", rd_cnt - rd0, 2);
        chk("rst_fifo_empty", fifo_q.size(), 0);
        chk("rd_err_total", rd_err, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        en_a = 1'b0;

        // One clock per bit, word 0x3C
        fb = 10'b1001111000;
        empty_b = 1'b0;
        en_b = 1'b1;
        tick();
        chk("c1_rd_en", rd_en_b, 1'b1);
        empty_b = 1'b1;
        tick();
        chk("c1_load_tx", tx_b, 1'b1);
        chk("c1_load_rd_en", rd_en_b, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("c1_tx_bit", tx_b, fb[i]);
            chk("c1_busy", busy_b, 1'b1);
            tick();
        end
        chk("c1_done", done_b, 1'b1);
        chk("c1_done_tx", tx_b, 1'b1);
        tick();
        chk("c1_done_once", done_b, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_tx_serializer.md
# fifo_tx_serializer

Downstream consumer of the synchronous FIFO. Pops one WIDTH-bit word at a time through the FIFO read port and shifts it out on a single serial line as an asynchronous-style frame: start bit 0, data LSB first, stop bit 1, each bit held for CLKS_PER_BIT clocks. It sits between the FIFO read side and the off-chip serial pin, and is the FIFO's only reader.

## Interface
- WIDTH, 8, data word width; must match the FIFO data width.
- CLKS_PER_BIT, 4, clocks per serial bit; legal range is 1 or greater.
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  permits starting a new frame; sampled only in IDLE.
- empty_i  input  1  FIFO empty flag.
- rd_en_o  output  1  FIFO read strobe; registered, one-cycle pulse.
- rdata_i  input  WIDTH  FIFO read data; valid the cycle after the rd_en_o pulse.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse on frame completion.

## Operation
- Reset values (applied asynchronously): state=IDLE, tx_o=1, rd_en_o=0, busy_o=0, done_o=0, shift register=0, bit counter=0, clock counter=0.
- FSM states are IDLE, REQ, LOAD, START, DATA, STOP. All outputs are registered.
- IDLE
  - If enable_i=1 and empty_i=0 at the edge, go to REQ.
  - Otherwise stay in IDLE with tx_o=1.
- REQ: rd_en_o=1 for exactly this cycle. Go to LOAD.
- LOAD
  - Capture rdata_i into the shift register. The FIFO updated its read data on the edge that sampled rd_en_o=1.
  - Go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - tx_o = shift[0] for CLKS_PER_BIT cycles per bit.
  - The register shifts right after each bit.
  - After WIDTH bits, go to STOP.
- STOP
  - tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - done_o=1 in the first IDLE cycle after STOP.
- Clock counter
  - Width is max(1, $clog2(CLKS_PER_BIT)).
  - Counts 0 to CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - With CLKS_PER_BIT=1, every bit lasts 1 cycle.
- Bit counter: width $clog2(WIDTH)+1, counts 0 to WIDTH-1.
- empty_i and enable_i are ignored outside IDLE.
  - Deasserting enable_i mid-frame has no effect; the frame completes.
  - At most one read is issued per frame, so the block never reads an empty FIFO (never causes a FIFO read error).
- Reset mid-frame
  - tx_o returns to 1 immediately. The frame and the captured word are abandoned.
  - The word stays consumed from the FIFO.

## Timing
- Edge-count convention: the edge that samples empty_i=0 in IDLE is edge E.
  - rd_en_o is high in cycle E+1.
  - LOAD is cycle E+2.
  - tx_o=0 from cycle E+3.
- Frame length on tx_o: (WIDTH+2)*CLKS_PER_BIT cycles.
- done_o is high in cycle E+3+(WIDTH+2)*CLKS_PER_BIT.
- Back-to-back words: the minimum inter-frame gap with tx_o=1 is 3 cycles (IDLE, REQ, LOAD). The done_o cycle is the IDLE cycle in which the next empty_i is sampled.
- busy_o is high from cycle E+1 through the last STOP cycle.

## Test plan
- Single byte, CLKS_PER_BIT=4: FIFO holds 0xA5, enable_i=1.
  - rd_en_o pulses exactly once.
  - tx_o = 0×4, then 1,0,1,0,0,1,0,1 each ×4, then 1×4 (40 cycles).
  - done_o pulses one cycle later.
- Back-to-back: FIFO holds 0x00 then 0xFF.
  - Two frames with exactly 3 idle-high cycles between them.
  - Two rd_en_o pulses; the FIFO ends empty.
  - No FIFO rd_error.
- Empty or disabled:
  - empty_i=1 for 50 cycles: rd_en_o=0, tx_o=1, busy_o=0 throughout.
  - enable_i=0 with a non-empty FIFO: same result.
  - Raising enable_i later starts a frame on the following cycle.
- enable_i drop mid-frame: deassert in DATA bit 3.
  - The frame completes and done_o pulses.
  - No new REQ follows.
- Reset mid-frame: assert rst_i asynchronously during DATA bit 5.
  - tx_o=1, busy_o=0, rd_en_o=0 before the next edge.
  - After release, the next FIFO word is sent intact.
- CLKS_PER_BIT=1, byte 0x3C:
  - 10-cycle frame 0,0,0,1,1,1,1,0,0,1.
  - done_o pulses at E+13.
